// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: accepts one load/store at a time, waits LATENCY
// cycles, then commits the access and returns a one-cycle response pulse.
module data_mem_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] mem [2**ADDR_W];

  logic              accept, commit, err, hi_bits;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wword, rword, load_val;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign commit    = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n)                        cnt <= 4'd0;
    else if (accept)                   cnt <= 4'(LATENCY - 1);
    else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;
  end

  // Request fields are only consumed after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign hi_bits = (addr_q >> (ADDR_W + 2)) != '0;
  assign err     = (size_q == 2'd3)
                || (size_q == 2'd1 && addr_q[0])
                || (size_q == 2'd2 && addr_q[1:0] != 2'b00)
                || hi_bits;
  assign idx     = addr_q[ADDR_W+1:2];
  assign lane    = addr_q[1:0];
  assign rword   = mem[idx];

  always_comb begin
    be    = 4'b0000;
    wword = '0;
    unique case (size_q)
      2'd0: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be    = 4'b0011 << {lane[1], 1'b0};
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_q;
      end
    endcase
  end

  always_comb begin
    sel_byte = rword[{lane, 3'b000} +: 8];
    sel_half = rword[{lane[1], 4'b0000} +: 16];
    unique case (size_q)
      2'd0:    load_val = {{24{~uns_q & sel_byte[7]}}, sel_byte};
      2'd1:    load_val = {{16{~uns_q & sel_half[15]}}, sel_half};
      default: load_val = rword;
    endcase
  end

  // NOTE: the memory array is deliberately not reset; only the write is gated by rst_n
  // so a reset landing on the commit edge suppresses the store.
  always_ff @(posedge clk) begin
    if (rst_n && commit && we_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= commit;
      if (commit) begin
        resp_err   <= err;
        resp_rdata <= (err || we_q) ? 32'h0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (LATENCY 2, 1, 15) share stimulus; a byte-addressed
// reference model predicts every response, plus literal checks on the LATENCY=2 instance.
module tb_data_mem_ctrl;
  localparam int AW = 10;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic [NI-1:0] rdy, vld, er;
  logic [31:0]   rd [NI];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(AW), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(vld[0]), .resp_rdata(rd[0]), .resp_err(er[0]));
  data_mem_ctrl #(.ADDR_W(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(vld[1]), .resp_rdata(rd[1]), .resp_err(er[1]));
  data_mem_ctrl #(.ADDR_W(AW), .LATENCY(15)) u_l15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(vld[2]), .resp_rdata(rd[2]), .resp_err(er[2]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Reference model: edge-count timing plus a byte-addressed memory per instance.
  int          e = 0;
  bit          seen_rst = 1'b0;
  bit          pend [NI];
  int          due [NI], free_e [NI];
  logic        p_we [NI], p_uns [NI];
  logic [1:0]  p_size [NI];
  logic [31:0] p_addr [NI], p_wdata [NI];
  bit          exp_v [NI], exp_er [NI], exp_known [NI];
  logic [31:0] exp_rd [NI];
  logic [7:0]  mb [NI][4096];
  bit          dfd [NI][4096];

  task automatic model_access(input int i);
    int n, base;
    logic [31:0] a, v;
    bit known;
    a = p_addr[i];
    n = 1 << p_size[i];
    exp_er[i] = (p_size[i] == 2'd3) || (p_size[i] == 2'd1 && a[0])
             || (p_size[i] == 2'd2 && a[1:0] != 2'b00) || (a >= 32'(1 << (AW + 2)));
    exp_rd[i] = '0;
    exp_known[i] = 1'b1;
    if (!exp_er[i]) begin
      base = int'(a[11:0]);
      if (p_we[i]) begin
        for (int b = 0; b < n; b++) begin
          mb[i][base + b]  = p_wdata[i][8*b +: 8];
          dfd[i][base + b] = 1'b1;
        end
      end else begin
        v = '0;
        known = 1'b1;
        for (int b = 0; b < n; b++) begin
          v[8*b +: 8] = mb[i][base + b];
          if (!dfd[i][base + b]) known = 1'b0;
        end
        if (!p_uns[i] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        exp_rd[i]    = v;
        exp_known[i] = known;
      end
    end
  endtask

  always @(posedge clk) begin
    e++;
    for (int i = 0; i < NI; i++) begin
      exp_v[i] = 1'b0;
      if (!rst_n) begin
        pend[i]   = 1'b0;
        free_e[i] = e + 1;
      end else if (pend[i] && e == due[i]) begin
        model_access(i);
        exp_v[i] = 1'b1;
        pend[i]  = 1'b0;
      end else if (!pend[i] && e >= free_e[i] && req_valid) begin
        p_we[i] = req_we; p_uns[i] = req_unsigned; p_size[i] = req_size;
        p_addr[i] = req_addr; p_wdata[i] = req_wdata;
        due[i]    = e + lat_of(i);
        free_e[i] = due[i] + 2;
        pend[i]   = 1'b1;
      end
    end
    if (!rst_n) seen_rst = 1'b1;
  end

  bit hold = 1'b0;
  int last_acc [NI] = '{-1, -1, -1};

  always @(negedge clk) begin
    if (seen_rst) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("ready_u%0d", i), 32'(rdy[i]), 32'(!pend[i] && (e + 1 >= free_e[i])));
        check($sformatf("valid_u%0d", i), 32'(vld[i]), 32'(exp_v[i]));
        if (exp_v[i] && vld[i]) begin
          check($sformatf("err_u%0d", i), 32'(er[i]), 32'(exp_er[i]));
          if (exp_known[i]) check($sformatf("rdata_u%0d", i), rd[i], exp_rd[i]);
        end
        if (hold && rdy[i] && req_valid) begin
          if (last_acc[i] >= 0)
            check($sformatf("spacing_u%0d", i), 32'(e - last_acc[i]), 32'(lat_of(i) + 2));
          last_acc[i] = e;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!rdy[0] && n < 50) begin
      tick();
      n++;
    end
    if (!rdy[0]) check("ready_timeout", 32'(rdy[0]), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clk);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    bit got;
    issue(we, addr, size, uns, wdata);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      if (vld[0]) got = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check({name, "_got"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_lat"}, 32'(n), 32'd2);
      check({name, "_rdata"}, rd[0], exp_rdata);
      check({name, "_err"}, 32'(er[0]), 32'(exp_err));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(rdy), 32'b111);
    check("rst_valid", 32'(vld), 32'b000);
    check("rst_err", 32'(er), 32'b000);
    check("rst_rdata", rd[0], 32'h0);
    rst_n = 1'b1;
    tick();

    do_req("st_w10",  1, 32'h10, 2, 0, 32'h1122_3344, 32'h0, 0);
    do_req("ld_w10",  0, 32'h10, 2, 0, 32'h0, 32'h1122_3344, 0);
    do_req("st_w00",  1, 32'h00, 2, 0, 32'h5566_7788, 32'h0, 0);
    do_req("st_b11",  1, 32'h11, 0, 0, 32'h0000_00AA, 32'h0, 0);
    do_req("ld_w10b", 0, 32'h10, 2, 0, 32'h0, 32'h1122_AA44, 0);
    do_req("ld_sb11", 0, 32'h11, 0, 0, 32'h0, 32'hFFFF_FFAA, 0);
    do_req("ld_ub11", 0, 32'h11, 0, 1, 32'h0, 32'h0000_00AA, 0);
    do_req("ld_sh12", 0, 32'h12, 1, 0, 32'h0, 32'h0000_1122, 0);
    do_req("ld_sh10", 0, 32'h10, 1, 0, 32'h0, 32'hFFFF_AA44, 0);
    do_req("ld_uh10", 0, 32'h10, 1, 1, 32'h0, 32'h0000_AA44, 0);
    do_req("ld_uw10", 0, 32'h10, 2, 1, 32'h0, 32'h1122_AA44, 0);

    do_req("e_ldh13",  0, 32'h13, 1, 0, 32'h0, 32'h0, 1);
    do_req("e_stw02",  1, 32'h02, 2, 0, 32'hCAFE_F00D, 32'h0, 1);
    do_req("e_size3s", 1, 32'h10, 3, 0, 32'hFFFF_FFFF, 32'h0, 1);
    do_req("e_size3l", 0, 32'h10, 3, 0, 32'h0, 32'h0, 1);
    do_req("e_oor",    1, 32'h0000_1000, 2, 0, 32'hBADB_AD00, 32'h0, 1);
    do_req("post_e10", 0, 32'h10, 2, 0, 32'h0, 32'h1122_AA44, 0);
    do_req("post_e00", 0, 32'h00, 2, 0, 32'h0, 32'h5566_7788, 0);

    do_req("st_w20", 1, 32'h20, 2, 0, 32'h0102_0304, 32'h0, 0);
    issue(1, 32'h20, 2, 0, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("abort_no_resp", 32'(vld[0]), 32'd0);
      tick();
    end
    do_req("ld_w20a", 0, 32'h20, 2, 0, 32'h0, 32'h0102_0304, 0);

    issue(1, 32'h20, 2, 0, 32'hDEAD_BEEF);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("commit_rst_no_resp", 32'(vld[0]), 32'd0);
    tick();
    do_req("ld_w20b", 0, 32'h20, 2, 0, 32'h0, 32'h0102_0304, 0);

    wait_ready();
    req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
    req_valid = 1'b1;
    hold = 1'b1;
    repeat (80) tick();
    hold = 1'b0;
    req_valid = 1'b0;
    repeat (20) tick();
    check("hold_accepts_u0", 32'(last_acc[0] >= 0), 32'd1);
    check("hold_accepts_u2", 32'(last_acc[2] >= 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: word-address bits; memory holds 2**ADDR_W 32-bit words; legal range ADDR_W 4..16.
REQ-002 Parameter LATENCY, default 2: cycles in WAIT before the access commits; legal range 1..15.
REQ-003 clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 req_valid  input  1: request present.
REQ-006 req_ready  output  1: block can accept a request this cycle.
REQ-007 req_we  input  1: 1 = store, 0 = load.
REQ-008 req_addr  input  32: byte address.
REQ-009 req_size  input  2: 0 = byte, 1 = halfword, 2 = word; 3 is illegal.
REQ-010 req_unsigned  input  1: loads only; 1 = zero-extend, 0 = sign-extend.
REQ-011 req_wdata  input  32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1: one-cycle response pulse.
REQ-013 resp_rdata  output  32: load result, extended; 0 for stores and errors.
REQ-014 resp_err  output  1: request rejected (misaligned, out of range, illegal size); qualified by resp_valid.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 Accept = req_valid && req_ready at a rising edge; on accept, latch all req_* fields, set counter to LATENCY-1, and move to WAIT.
REQ-017 Inputs are ignored outside IDLE; no request queueing.
REQ-018 WAIT with counter != 0: decrement the counter. WAIT with counter == 0: perform the access, register the response, and move to RESP.
REQ-019 RESP lasts exactly one cycle with resp_valid = 1, then moves to IDLE; no response backpressure.
REQ-020 Timing: a request accepted at edge k gives resp_valid high during the cycle after edge k+LATENCY; the next accept is possible at edge k+LATENCY+2 at the earliest.
REQ-021 Word index = addr[ADDR_W+1:2]. Byte lane = addr[1:0], little-endian: lane n = bits [8n+7:8n].
REQ-022 Error conditions:
  - size 3
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - addr[31:ADDR_W+2] != 0
REQ-023 An errored request still follows the full WAIT/RESP timing, sets resp_err = 1 and resp_rdata = 0, and does not modify memory.
REQ-024 Store writes only the addressed lanes; other bytes of the word are unchanged.
  - byte: wdata[7:0] to lane addr[1:0]
  - half: wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1
  - word: all lanes
REQ-025 The store commits on the same edge that enters RESP; a load issued afterwards returns the new data.
REQ-026 Load selects the addressed byte or halfword and extends it to 32 bits per the latched req_unsigned; word loads are unaffected by req_unsigned.
REQ-027 resp_rdata and resp_err hold their registered values until the next response; they are meaningful only while resp_valid = 1.

Reset
REQ-028 When rst_n = 0 at an edge: state IDLE, counter 0, resp_valid 0, resp_err 0, resp_rdata 0; req_ready reads 1 in the following cycle.
REQ-029 Reset in WAIT aborts the pending request: no memory write and no response.
REQ-030 Reset arriving on the commit edge takes priority: no write occurs.
REQ-031 Memory array contents are not reset and are undefined until written.

Verification
REQ-032 LATENCY=2: store word 0x11223344 to 0x10, then word load from 0x10 -> resp_rdata 0x11223344, resp_err 0; resp_valid high exactly 2 cycles after each accept edge, for one cycle.
REQ-033 Byte/half stores: byte store 0xAA to 0x11, then word load 0x10 -> 0x1122AA44; signed byte load 0x11 -> 0xFFFFFFAA; unsigned -> 0x000000AA; signed half load 0x12 -> 0x00001122.
REQ-034 Errors: half load at 0x13, word store at 0x02, size 3, and addr 0x00001000 (ADDR_W=10) -> each gives resp_err 1, resp_rdata 0, memory unchanged.
REQ-035 Handshake: req_valid held high continuously -> req_ready low in WAIT/RESP, requests accepted only in IDLE, spacing LATENCY+2 cycles; LATENCY=1 and LATENCY=15 both checked.
REQ-036 Reset mid-WAIT of a word store of 0xDEADBEEF to 0x20 -> no response; a subsequent load of 0x20 returns the prior value.
